// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one prescaled up/down/centre timebase drives NUM_CH
// compare channels whose configuration is double-buffered to period boundaries.
module pwm_multi_channel #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4,
    parameter int PSC_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cnt_en,
    input  logic                    cnt_clr,
    input  logic [1:0]              cnt_mode,
    input  logic [CNT_W-1:0]        period,
    input  logic [PSC_W-1:0]        prescale,
    input  logic                    upd_lock,
    input  logic [NUM_CH*CNT_W-1:0] ch_cmp1,
    input  logic [NUM_CH*CNT_W-1:0] ch_cmp2,
    input  logic [NUM_CH*2-1:0]     ch_func,
    input  logic [NUM_CH-1:0]       ch_pol,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [CNT_W-1:0]        cnt_val,
    output logic                    cnt_dir,
    output logic                    period_evt,
    output logic [NUM_CH-1:0]       pwm_out
);

    localparam logic [1:0] M_DN    = 2'b01;
    localparam logic [1:0] M_CTR   = 2'b10;
    localparam logic [1:0] F_LEFT  = 2'b00;
    localparam logic [1:0] F_RIGHT = 2'b01;
    localparam logic [1:0] F_RANGE = 2'b10;

    logic [CNT_W-1:0]        per_q, per_d;
    logic [PSC_W-1:0]        psc_q, psc_d;
    logic [1:0]              mode_q, mode_d;
    logic [NUM_CH*CNT_W-1:0] cmp1_q, cmp1_d;
    logic [NUM_CH*CNT_W-1:0] cmp2_q, cmp2_d;
    logic [NUM_CH*2-1:0]     func_q, func_d;
    logic [NUM_CH-1:0]       pol_q, pol_d;

    logic [PSC_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              evt_q, evt_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;

    logic             tick, load, clr_new, clr_dn;
    logic [CNT_W-1:0] clr_per, c1, c2;
    logic             raw;

    // Clear resolves against whatever the active registers hold after this edge
    always_comb begin
        clr_new = !cnt_en || !upd_lock;
        clr_per = clr_new ? period : per_q;
        clr_dn  = (clr_new ? cnt_mode : mode_q) == M_DN;
        tick    = cnt_en && !cnt_clr && (pre_q >= psc_q);
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        evt_d   = 1'b0;
        pre_d   = pre_q;
        if (cnt_clr) begin
            pre_d = '0;
            cnt_d = clr_dn ? clr_per : '0;
            dir_d = !clr_dn;
        end else if (cnt_en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                case (mode_q)
                    M_DN: begin
                        dir_d = 1'b0;
                        if (cnt_q == '0) begin
                            cnt_d = per_q;
                            evt_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    M_CTR: begin
                        if (per_q == '0) begin
                            cnt_d = '0;
                            dir_d = 1'b1;
                            evt_d = 1'b1;
                        end else if (dir_q) begin
                            if (cnt_q == per_q) begin
                                dir_d = 1'b0;
                                cnt_d = cnt_q - 1'b1;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else if (cnt_q == '0) begin
                            dir_d = 1'b1;
                            cnt_d = cnt_q + 1'b1;
                            evt_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        dir_d = 1'b1;
                        if (cnt_q == per_q) begin
                            cnt_d = '0;
                            evt_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        load   = !cnt_en || ((evt_d || cnt_clr) && !upd_lock);
        per_d  = load ? period   : per_q;
        psc_d  = load ? prescale : psc_q;
        mode_d = load ? cnt_mode : mode_q;
        cmp1_d = load ? ch_cmp1  : cmp1_q;
        cmp2_d = load ? ch_cmp2  : cmp2_q;
        func_d = load ? ch_func  : func_q;
        pol_d  = load ? ch_pol   : pol_q;
    end

    always_comb begin
        pwm_d = '0;
        c1    = '0;
        c2    = '0;
        raw   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            c1 = cmp1_q[i*CNT_W +: CNT_W];
            c2 = cmp2_q[i*CNT_W +: CNT_W];
            case (func_q[i*2 +: 2])
                F_LEFT:  raw = cnt_q < c1;
                F_RIGHT: raw = cnt_q >= c1;
                F_RANGE: raw = (cnt_q >= c1) && (cnt_q < c2);
                default: raw = 1'b0;
            endcase
            pwm_d[i] = ch_en[i] & (raw ^ pol_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q  <= period;
            psc_q  <= prescale;
            mode_q <= cnt_mode;
            cmp1_q <= ch_cmp1;
            cmp2_q <= ch_cmp2;
            func_q <= ch_func;
            pol_q  <= ch_pol;
            pre_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b1;
            evt_q  <= 1'b0;
            pwm_q  <= '0;
        end else begin
            per_q  <= per_d;
            psc_q  <= psc_d;
            mode_q <= mode_d;
            cmp1_q <= cmp1_d;
            cmp2_q <= cmp2_d;
            func_q <= func_d;
            pol_q  <= pol_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            evt_q  <= evt_d;
            pwm_q  <= pwm_d;
        end
    end

    assign cnt_val    = cnt_q;
    assign cnt_dir    = dir_q;
    assign period_evt = evt_q;
    assign pwm_out    = pwm_q;

endmodule
